// File: rtl/writeback_pkg.sv
// Shared encodings for the writeback stage: opsizes, FSM states, and the
// byte-enable masks used to build store beats.
package writeback_pkg;

  typedef enum logic [1:0] {
    SZ_8  = 2'b00,
    SZ_16 = 2'b01,
    SZ_32 = 2'b10,
    SZ_64 = 2'b11
  } opsize_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REG,
    ST_MEM0,
    ST_MEM1,
    ST_DONE
  } state_e;

  localparam logic [3:0] BE_8  = 4'b0001;
  localparam logic [3:0] BE_16 = 4'b0011;
  localparam logic [3:0] BE_32 = 4'b1111;

  // Byte mask of an op before shifting it into its lanes; 64-bit uses full words.
  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    case (sz)
      SZ_8:    return BE_8;
      SZ_16:   return BE_16;
      default: return BE_32;
    endcase
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/wb_store_align.sv
// Combinational store aligner: turns address/opsize/result into up to two
// word-aligned beats with lane-shifted data and byte enables.
module wb_store_align
  import writeback_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int RES_W  = 64
) (
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [1:0]        i_opsize,
  input  logic [RES_W-1:0]  i_result,
  output logic [ADDR_W-1:0] o_addr0,
  output logic [ADDR_W-1:0] o_addr1,
  output logic [31:0]       o_data0,
  output logic [31:0]       o_data1,
  output logic [3:0]        o_be0,
  output logic [3:0]        o_be1,
  output logic              o_split,
  output logic              o_misalign
);
  logic        w_is64;
  logic [1:0]  w_off;
  logic [3:0]  w_mask;
  logic [31:0] w_lo;
  logic [7:0]  w_be_wide;
  logic [63:0] w_data_wide;

  // 64-bit stores ignore the low address bits and go out as two full words.
  assign w_is64      = (i_opsize == SZ_64);
  assign w_off       = w_is64 ? 2'b00 : i_addr[1:0];
  assign w_mask      = size_mask(i_opsize);
  assign w_lo        = i_result[31:0] & lane_mask(w_mask);
  assign w_be_wide   = {4'b0000, w_mask} << w_off;
  assign w_data_wide = {32'd0, w_lo} << {w_off, 3'b000};

  assign o_addr0    = {i_addr[ADDR_W-1:2], 2'b00};
  assign o_addr1    = o_addr0 + ADDR_W'(4);
  assign o_be0      = w_is64 ? 4'hF : w_be_wide[3:0];
  assign o_be1      = w_is64 ? 4'hF : w_be_wide[7:4];
  assign o_data0    = w_is64 ? i_result[31:0]  : w_data_wide[31:0];
  assign o_data1    = w_is64 ? i_result[63:32] : w_data_wide[63:32];
  assign o_split    = w_is64 | (|w_be_wide[7:4]);
  assign o_misalign = w_is64 & (|i_addr[1:0]);

endmodule

// File: rtl/writeback_top.sv
// Writeback stage: holds one retired op, commits it to the register file or
// to memory in one or two beats, and signals redirect/sys-controller events.
module writeback_top
  import writeback_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int RES_W  = 64,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [ADDR_W-1:0] wb_dest_address,
  input  logic [2:0]        wb_dest_reg,
  input  logic [RES_W-1:0]  wb_result,
  input  logic [1:0]        wb_opsize,
  input  logic              wb_mem_or_reg,
  input  logic              wb_to_sys_controller,
  input  logic [ADDR_W-1:0] wb_pc,
  input  logic              wb_br_misprediction,
  input  logic              wb_jump_load_cs,
  input  logic [31:0]       wb_cs_out,
  output logic              reg_we,
  output logic [2:0]        reg_sel,
  output logic [RES_W-1:0]  reg_data,
  output logic [1:0]        reg_size,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data,
  output logic [3:0]        mem_be,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              redirect_load_cs,
  output logic [31:0]       redirect_cs,
  output logic              sys_notify,
  output logic [ADDR_W-1:0] sys_pc,
  output logic              align_err,
  output logic [CNT_W-1:0]  retire_count
);
  state_e            r_state, w_next;
  logic [ADDR_W-1:0] r_addr, r_pc;
  logic [2:0]        r_reg;
  logic [RES_W-1:0]  r_res;
  logic [1:0]        r_size;
  logic              r_sys, r_br, r_lcs;
  logic [31:0]       r_cs;
  logic              r_align_err;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_accept, w_retire;
  logic [ADDR_W-1:0] w_addr0, w_addr1;
  logic [31:0]       w_data0, w_data1;
  logic [3:0]        w_be0, w_be1;
  logic              w_split, w_misalign;

  wb_store_align #(.ADDR_W(ADDR_W), .RES_W(RES_W)) u_align (
    .i_addr(r_addr), .i_opsize(r_size), .i_result(r_res),
    .o_addr0(w_addr0), .o_addr1(w_addr1), .o_data0(w_data0), .o_data1(w_data1),
    .o_be0(w_be0), .o_be1(w_be1), .o_split(w_split), .o_misalign(w_misalign)
  );

  // Flush only has effect while the held op is still uncommitted (IDLE/REG).
  assign wb_ready = (r_state == ST_IDLE) || (r_state == ST_REG);
  assign w_accept = wb_valid && wb_ready && !flush;
  assign w_retire = ((r_state == ST_REG) && !flush) || (r_state == ST_DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr <= '0; r_pc <= '0; r_reg <= '0; r_res <= '0; r_size <= '0;
      r_sys  <= 1'b0; r_br <= 1'b0; r_lcs <= 1'b0; r_cs <= '0;
    end else if (w_accept) begin
      r_addr <= wb_dest_address; r_pc <= wb_pc; r_reg <= wb_dest_reg;
      r_res  <= wb_result; r_size <= wb_opsize;
      r_sys  <= wb_to_sys_controller; r_br <= wb_br_misprediction;
      r_lcs  <= wb_jump_load_cs; r_cs <= wb_cs_out;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt       <= '0;
      r_align_err <= 1'b0;
    end else begin
      if (w_retire) r_cnt <= r_cnt + CNT_W'(1);
      if ((r_state == ST_MEM0) && w_misalign) r_align_err <= 1'b1;
    end
  end

  always_comb begin
    w_next           = r_state;
    reg_we           = 1'b0;
    mem_req          = 1'b0;
    mem_addr         = w_addr0;
    mem_data         = w_data0;
    mem_be           = w_be0;
    case (r_state)
      ST_IDLE, ST_REG: begin
        reg_we = (r_state == ST_REG) && !flush;
        if (w_accept) w_next = wb_mem_or_reg ? ST_MEM0 : ST_REG;
        else          w_next = ST_IDLE;
      end
      ST_MEM0: begin
        mem_req = 1'b1;
        if (mem_ack) w_next = w_split ? ST_MEM1 : ST_DONE;
      end
      ST_MEM1: begin
        mem_req  = 1'b1;
        mem_addr = w_addr1;
        mem_data = w_data1;
        mem_be   = w_be1;
        if (mem_ack) w_next = ST_DONE;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  assign reg_sel          = r_reg;
  assign reg_data         = r_res;
  assign reg_size         = r_size;
  assign redirect_valid   = w_retire && r_br;
  assign redirect_pc      = ADDR_W'(r_res[31:0]);
  assign redirect_load_cs = r_lcs;
  assign redirect_cs      = r_cs;
  assign sys_notify       = w_retire && r_sys;
  assign sys_pc           = r_pc;
  assign align_err        = r_align_err;
  assign retire_count     = r_cnt;

endmodule

// File: tb/tb_writeback_top.sv
// Bench for writeback_top: a byte-level store model plus event queues predict
// every register write, memory beat, redirect and sys notification.
module tb_writeback_top;
  logic        clk = 1'b0, reset = 1'b0, flush = 1'b0, wb_valid = 1'b0;
  logic        wb_ready;
  logic [31:0] wb_dest_address = '0, wb_pc = '0, wb_cs_out = '0;
  logic [2:0]  wb_dest_reg = '0;
  logic [63:0] wb_result = '0;
  logic [1:0]  wb_opsize = '0;
  logic        wb_mem_or_reg = 1'b0, wb_to_sys_controller = 1'b0;
  logic        wb_br_misprediction = 1'b0, wb_jump_load_cs = 1'b0;
  logic        reg_we, mem_req, mem_ack = 1'b0;
  logic [2:0]  reg_sel;
  logic [63:0] reg_data;
  logic [1:0]  reg_size;
  logic [31:0] mem_addr, mem_data, redirect_pc, redirect_cs, sys_pc, retire_count;
  logic [3:0]  mem_be;
  logic        redirect_valid, redirect_load_cs, sys_notify, align_err;

  writeback_top dut (
    .clk(clk), .reset(reset), .flush(flush), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_dest_address(wb_dest_address), .wb_dest_reg(wb_dest_reg), .wb_result(wb_result),
    .wb_opsize(wb_opsize), .wb_mem_or_reg(wb_mem_or_reg),
    .wb_to_sys_controller(wb_to_sys_controller), .wb_pc(wb_pc),
    .wb_br_misprediction(wb_br_misprediction), .wb_jump_load_cs(wb_jump_load_cs),
    .wb_cs_out(wb_cs_out), .reg_we(reg_we), .reg_sel(reg_sel), .reg_data(reg_data),
    .reg_size(reg_size), .mem_req(mem_req), .mem_ack(mem_ack), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_be(mem_be), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .redirect_load_cs(redirect_load_cs),
    .redirect_cs(redirect_cs), .sys_notify(sys_notify), .sys_pc(sys_pc),
    .align_err(align_err), .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [2:0] sel; logic [63:0] data; logic [1:0] size; } regw_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; logic [3:0] be; } beat_t;
  typedef struct { logic [31:0] pc; logic lcs; logic [31:0] cs; } redir_t;

  regw_t       rq[$];
  beat_t       bq[$];
  beat_t       mb[$];
  redir_t      dq[$];
  logic [31:0] sq[$];
  int          model_cnt = 0;
  int          total = 0, bad = 0;
  int          ack_pct = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lanes(input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction

  // Walk the store byte by byte; each new word address starts a new beat.
  task automatic build_beats(input logic [31:0] addr, input logic [1:0] sz, input logic [63:0] res);
    int          n;
    int          lane;
    logic [31:0] base, a;
    beat_t       cur;
    bit          have;
    mb.delete();
    n    = 1 << sz;
    base = (sz == 2'b11) ? (addr & 32'hFFFF_FFFC) : addr;
    have = 0;
    cur  = '{addr: 32'h0, data: 32'h0, be: 4'h0};
    for (int i = 0; i < n; i++) begin
      a    = base + 32'(i);
      lane = int'(a[1:0]);
      if (have && cur.addr != {a[31:2], 2'b00}) begin mb.push_back(cur); have = 0; end
      if (!have) begin cur.addr = {a[31:2], 2'b00}; cur.data = '0; cur.be = '0; have = 1; end
      cur.data[8*lane +: 8] = res[8*i +: 8];
      cur.be[lane] = 1'b1;
    end
    mb.push_back(cur);
  endtask

  task automatic send(input bit mem, input logic [31:0] addr, input logic [2:0] rd,
                      input logic [63:0] res, input logic [1:0] sz, input bit sys,
                      input logic [31:0] pc, input bit br, input bit lcs,
                      input logic [31:0] cs, output int waited);
    int n = 0;
    wb_valid = 1'b1; wb_mem_or_reg = mem; wb_dest_address = addr; wb_dest_reg = rd;
    wb_result = res; wb_opsize = sz; wb_to_sys_controller = sys; wb_pc = pc;
    wb_br_misprediction = br; wb_jump_load_cs = lcs; wb_cs_out = cs;
    while (!wb_ready && n < 500) begin @(posedge clk); #2; n++; end
    waited = n;
    if (!wb_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout: wb_ready=%0b expected 1", wb_ready);
      wb_valid = 1'b0;
      return;
    end
    if (!mem) rq.push_back('{sel: rd, data: res, size: sz});
    else begin
      build_beats(addr, sz, res);
      foreach (mb[i]) bq.push_back(mb[i]);
    end
    if (br)  dq.push_back('{pc: res[31:0], lcs: lcs, cs: cs});
    if (sys) sq.push_back(pc);
    model_cnt++;
    @(posedge clk); #2;
    wb_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    ack_pct = 100;
    while (n < 3000 && !(rq.size() == 0 && bq.size() == 0 && dq.size() == 0 &&
                         sq.size() == 0 && wb_ready)) begin
      @(posedge clk); #2; n++;
    end
    total++;
    if (n >= 3000) begin
      bad++;
      $display("FAIL drain_timeout: pending reg=%0d beat=%0d redir=%0d sys=%0d expected all 0",
               rq.size(), bq.size(), dq.size(), sq.size());
    end
    @(posedge clk); #2;
  endtask

  always begin
    @(posedge clk); #1;
    mem_ack = ($urandom_range(0, 99) < ack_pct);
  end

  regw_t  er;
  beat_t  eb;
  redir_t ed;
  always @(negedge clk) begin
    if (reset) begin
      if (reg_we) begin
        total++;
        if (rq.size() == 0) begin bad++; $display("FAIL reg_we_extra: got 1 expected 0"); end
        else begin
          er = rq.pop_front();
          chk("reg_sel", reg_sel, er.sel); chk("reg_data", reg_data, er.data);
          chk("reg_size", reg_size, er.size);
        end
      end
      if (mem_req) chk("ready_in_store", wb_ready, 0);
      if (mem_req && mem_ack) begin
        total++;
        if (bq.size() == 0) begin bad++; $display("FAIL beat_extra: addr %0h expected none", mem_addr); end
        else begin
          eb = bq.pop_front();
          chk("beat_addr", mem_addr, eb.addr); chk("beat_be", mem_be, eb.be);
          chk("beat_data", mem_data & lanes(eb.be), eb.data & lanes(eb.be));
        end
      end
      if (redirect_valid) begin
        total++;
        if (dq.size() == 0) begin bad++; $display("FAIL redirect_extra: got 1 expected 0"); end
        else begin
          ed = dq.pop_front();
          chk("redirect_pc", redirect_pc, ed.pc); chk("redirect_lcs", redirect_load_cs, ed.lcs);
          chk("redirect_cs", redirect_cs, ed.cs);
        end
      end
      if (sys_notify) begin
        total++;
        if (sq.size() == 0) begin bad++; $display("FAIL sys_extra: got 1 expected 0"); end
        else chk("sys_pc", sys_pc, sq.pop_front());
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, gap, cnt0;
    logic [1:0] sz;
    #3;
    chk("rst_ready", wb_ready, 1); chk("rst_reg_we", reg_we, 0); chk("rst_mem_req", mem_req, 0);
    chk("rst_align", align_err, 0); chk("rst_count", retire_count, 0);
    chk("rst_redirect", redirect_valid, 0); chk("rst_sys", sys_notify, 0);

    build_beats(32'h2003, 2'b01, 64'h1234);
    chk("pin16_n", mb.size(), 2);
    chk("pin16_a0", mb[0].addr, 32'h2000); chk("pin16_be0", mb[0].be, 4'b1000);
    chk("pin16_d0", mb[0].data, 32'h3400_0000);
    chk("pin16_a1", mb[1].addr, 32'h2004); chk("pin16_be1", mb[1].be, 4'b0001);
    chk("pin16_d1", mb[1].data, 32'h0000_0012);
    build_beats(32'h3002, 2'b11, 64'h1122_3344_5566_7788);
    chk("pin64_a0", mb[0].addr, 32'h3000); chk("pin64_d0", mb[0].data, 32'h5566_7788);
    chk("pin64_a1", mb[1].addr, 32'h3004); chk("pin64_d1", mb[1].data, 32'h1122_3344);
    chk("pin64_be1", mb[1].be, 4'hF);

    @(posedge clk); #2; reset = 1'b1;
    @(posedge clk); #2;

    for (int i = 1; i <= 3; i++) begin
      send(0, 0, 3'(i), 64'(9 + i), 2'b10, 0, 0, 0, 0, 0, w);
      chk("b2b_wait", w, 0);
    end
    drain();
    chk("b2b_count", retire_count, 3);

    ack_pct = 0;
    send(1, 32'h1000, 0, 64'hDEAD_BEEF, 2'b10, 0, 0, 0, 0, 0, w);
    for (int i = 0; i < 3; i++) begin
      chk("st32_req", mem_req, 1); chk("st32_addr", mem_addr, 32'h1000);
      chk("st32_be", mem_be, 4'hF); chk("st32_data", mem_data, 32'hDEAD_BEEF);
      @(posedge clk); #2;
    end
    drain();
    chk("st32_count", retire_count, 4);
    send(1, 32'h2003, 0, 64'h1234, 2'b01, 0, 0, 0, 0, 0, w);
    send(1, 32'h3000, 0, 64'h1122_3344_5566_7788, 2'b11, 1, 32'h77, 0, 0, 0, w);
    drain();
    chk("align_clear", align_err, 0);
    send(1, 32'h3002, 0, 64'h1122_3344_5566_7788, 2'b11, 0, 0, 0, 0, 0, w);
    drain();
    chk("align_set", align_err, 1);
    send(0, 0, 3'd5, 64'h400, 2'b10, 0, 0, 1, 1, 32'h8, w);
    drain();
    chk("misp_count", retire_count, 8);

    for (int k = 0; k < 300; k++) begin
      ack_pct = $urandom_range(20, 100);
      sz = 2'($urandom_range(0, 3));
      send($urandom_range(0, 1) == 1, $urandom, 3'($urandom_range(0, 7)),
           {$urandom, $urandom}, sz, $urandom_range(0, 3) == 0, $urandom,
           $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, $urandom, w);
      gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      repeat (gap) begin @(posedge clk); #2; end
    end
    drain();
    chk("rand_count", retire_count, 32'(model_cnt));

    cnt0 = model_cnt;
    wb_valid = 1'b1; wb_mem_or_reg = 0; wb_dest_reg = 3'd6; wb_result = 64'h55;
    wb_br_misprediction = 1; wb_to_sys_controller = 1;
    @(posedge clk); #2;
    flush = 1'b1; wb_dest_reg = 3'd7;
    #1 chk("flush_reg_we", reg_we, 0);
    chk("flush_redirect", redirect_valid, 0);
    @(posedge clk); #2;
    flush = 1'b0; wb_valid = 1'b0;
    chk("flush_idle", wb_ready, 1); chk("flush_count", retire_count, 32'(cnt0));
    @(posedge clk); #2;
    chk("flush_drop", reg_we, 0); chk("flush_count2", retire_count, 32'(cnt0));

    ack_pct = 0;
    send(1, 32'h4001, 0, 64'hA1B2_C3D4, 2'b10, 0, 0, 1, 0, 32'h33, w);
    flush = 1'b1;
    repeat (2) begin @(posedge clk); #2; end
    flush = 1'b0;
    chk("flush_mem_req", mem_req, 1);
    drain();
    chk("flush_mem_count", retire_count, 32'(model_cnt));

    ack_pct = 0;
    send(1, 32'h5000, 0, 64'hCAFE_0000_BEEF_0000, 2'b11, 0, 0, 0, 0, 0, w);
    ack_pct = 100;
    @(posedge clk); #2;
    ack_pct = 0;
    @(posedge clk); #2;
    chk("mem1_req", mem_req, 1); chk("mem1_addr", mem_addr, 32'h5004);
    reset = 1'b0;
    #1;
    chk("rst_mid_req", mem_req, 0); chk("rst_mid_ready", wb_ready, 1);
    chk("rst_mid_count", retire_count, 0); chk("rst_mid_align", align_err, 0);
    rq.delete(); bq.delete(); dq.delete(); sq.delete(); model_cnt = 0;
    @(posedge clk); #2; reset = 1'b1;
    send(0, 0, 3'd2, 64'h99, 2'b00, 0, 0, 0, 0, 0, w);
    drain();
    chk("post_rst_count", retire_count, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/writeback_top.md
Name: writeback_top

Overview:
- Final pipeline stage, directly downstream of the execute pipestage.
- Accepts one retired instruction per handshake: result, destination register or memory address, opsize, control flags.
- Commits the result to the register file (single-cycle write pulse) or to memory through a 32-bit req/ack write port, splitting wide or unaligned stores into beats.
- Raises a one-cycle front-end redirect on branch misprediction and a sys-controller notification, and counts retired instructions.

Parameters:
- ADDR_W, 32, memory address and PC width
- RES_W, 64, result width (MMX-size operands)
- CNT_W, 32, retire counter width

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- flush  in  1  sys-controller flush; discards held, uncommitted ops
- wb_valid  in  1  execute pipestage output valid
- wb_ready  out  1  this stage can accept
- wb_dest_address  in  ADDR_W  memory destination
- wb_dest_reg  in  3  register destination index
- wb_result  in  RES_W  result data
- wb_opsize  in  2  00=8b 01=16b 10=32b 11=64b
- wb_mem_or_reg  in  1  1=memory store, 0=register write
- wb_to_sys_controller  in  1  op must notify sys controller
- wb_pc  in  ADDR_W  PC of op
- wb_br_misprediction  in  1  redirect required
- wb_jump_load_cs  in  1  redirect also loads CS
- wb_cs_out  in  32  new CS value
- reg_we  out  1  register write strobe, one cycle
- reg_sel  out  3  register index
- reg_data  out  RES_W  write data
- reg_size  out  2  opsize of write
- mem_req  out  1  memory write request
- mem_ack  in  1  memory accepted beat
- mem_addr  out  ADDR_W  word-aligned beat address
- mem_data  out  32  beat data, byte-lane aligned
- mem_be  out  4  byte enables
- redirect_valid  out  1  one-cycle redirect pulse
- redirect_pc  out  ADDR_W  target, = result[31:0]
- redirect_load_cs  out  1  load CS with redirect_cs
- redirect_cs  out  32  CS value
- sys_notify  out  1  one-cycle pulse with PC of op
- sys_pc  out  ADDR_W  PC for sys controller
- align_err  out  1  sticky; 64-bit store with addr[1:0]!=0
- retire_count  out  CNT_W  retired instruction count

Behaviour:
- Reset (reset=0, async): state IDLE; all strobes, mem_req, align_err, retire_count = 0; data outputs 0.
- States:
  - IDLE: empty.
  - REG: held register op.
  - MEM0: first store beat.
  - MEM1: second store beat.
  - DONE: retire store.
- Accept: wb_valid & wb_ready latches all inputs into holding register.
  - Next state REG if mem_or_reg=0, else MEM0.
- wb_ready = (state==IDLE) | (state==REG). Register-only streams therefore sustain 1 op/cycle.
- REG, one cycle:
  - reg_we=1, sel/data/size from held op.
  - Retires; leaves for the state chosen by a same-cycle accept, else IDLE.
- MEM0: mem_req=1 until mem_ack; address and data stable while req high.
  - 8/16/32-bit: mem_addr={addr[31:2],2'b00}; mem_be = size mask << addr[1:0]; data shifted left by 8*addr[1:0].
  - If addr[1:0]+bytes>4, the access is split: MEM1 carries the remaining bytes at word addr+4 with lanes starting at 0.
  - 64-bit: MEM0 = result[31:0] at addr, be=1111; MEM1 = result[63:32] at addr+4, be=1111.
  - 64-bit with addr[1:0]!=0: set align_err and perform the store as if aligned (addr[1:0] forced 0).
- Exit from MEM0: on ack go to MEM1 if split/64-bit, else DONE. MEM1 behaves the same, then DONE.
- DONE: retires, then IDLE.
- Retire cycle (REG or DONE):
  - retire_count += 1; wraps at 2^CNT_W-1 -> 0.
  - If br_misprediction: redirect_valid=1, redirect_pc=result[31:0], redirect_load_cs=jump_load_cs, redirect_cs=cs_out.
  - If to_sys_controller: sys_notify=1, sys_pc=pc.
- Register ops are not delayed by mem_ack.
- flush:
  - In IDLE/REG: held op discarded. No reg_we, no retire, no redirect. State -> IDLE; a same-cycle accept is dropped.
  - In MEM0/MEM1/DONE: ignored. The store is committed and completes and retires normally.
- mem_ack while mem_req=0: ignored.
- Mid-operation reset: immediate return to IDLE; the store is abandoned; mem_req drops asynchronously.

Decomposition:
- Shared package: opsize encodings, state encodings, byte-enable mask constants (0001/0011/1111).
- One sub-module, wb_store_align: combinational; maps addr/opsize/result to beat0/beat1 addr, data, be and split flag.
- The FSM, holding register and counters stay in writeback_top.

Test Plan:
- Back-to-back reg ops: three ops, dest 1,2,3, result 0xA,0xB,0xC, wb_valid held high.
  - Expect: reg_we on 3 consecutive cycles, wb_ready stays 1, retire_count=3.
- Aligned 32-bit store: addr 0x1000, result 0xDEADBEEF, mem_ack delayed 3 cycles.
  - Expect: one beat with addr 0x1000, be=1111, wb_ready=0 until DONE, then retire.
- Unaligned 16-bit store: addr 0x2003, result 0x1234.
  - Expect: beat0 addr 0x2000 be=1000 data=0x34000000; beat1 addr 0x2004 be=0001 data=0x00000012.
- 64-bit store: addr 0x3000, result 0x11223344_55667788.
  - Expect: beat0 data 0x55667788 @0x3000; beat1 data 0x11223344 @0x3004; align_err=0.
  - Repeat at addr 0x3002: expect align_err=1 and beats at 0x3000/0x3004.
- Misprediction: reg op with br_misprediction=1, jump_load_cs=1, result 0x400, cs_out 0x8.
  - Expect: one-cycle redirect_valid, redirect_pc 0x400, redirect_cs 0x8, redirect_load_cs=1.
- Flush and reset:
  - flush in REG: expect no reg_we, count unchanged.
  - flush in MEM0: expect the store still completes.
  - reset=0 in MEM1: expect mem_req=0 immediately, state IDLE, count=0.
